// File: rtl/rotor_pkg.sv
// Shared types and defaults for the rotor stepping block.
package rotor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_ODO    = 1'b0,
        MODE_ENIGMA = 1'b1
    } mode_t;

    localparam int unsigned DEF_MOD   = 26;
    localparam int unsigned DEF_W     = 5;
    // Rotors I/II/III right to left: field 0 = V(21), 1 = E(4), 2 = Q(16)
    localparam logic [3*DEF_W-1:0] DEF_NOTCH = {5'd16, 5'd4, 5'd21};

endpackage

// File: rtl/rotor_cell.sv
// One modulo-MOD rotor position register with step, direction, load and clear.
module rotor_cell #(
    parameter int unsigned    MOD   = 26,
    parameter int unsigned    W     = $clog2(MOD),
    parameter logic [W-1:0]   NOTCH = '0
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         step,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pos,
    output logic         at_max,
    output logic         at_zero,
    output logic         at_notch
);

    localparam logic [W-1:0] MAX   = W'(MOD - 1);
    localparam logic [W:0]   MOD_X = (W+1)'(MOD);

    logic load_ok;

    assign load_ok  = ({1'b0, load_val} < MOD_X);
    assign at_max   = (pos == MAX);
    assign at_zero  = (pos == '0);
    assign at_notch = (pos == NOTCH);

    // Out-of-range load values collapse to 0 so the register never leaves 0..MOD-1.
    always_ff @(posedge clk) begin
        if (clear) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_ok ? load_val : '0;
        end else if (step) begin
            if (dir)
                pos <= at_zero ? MAX : pos - W'(1);
            else
                pos <= at_max ? '0 : pos + W'(1);
        end
    end

endmodule

// File: rtl/rotor_stepper.sv
// Chain of NUM_ROTORS mod-MOD rotors stepped in bursts, odometer or Enigma style.
module rotor_stepper
    import rotor_pkg::*;
#(
    parameter int unsigned                NUM_ROTORS = 3,
    parameter int unsigned                MOD        = DEF_MOD,
    parameter int unsigned                W          = $clog2(MOD),
    parameter int unsigned                CNT_W      = 8,
    parameter logic [NUM_ROTORS*W-1:0]    NOTCH_POS  = DEF_NOTCH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    dir,
    input  logic                    start,
    input  logic [CNT_W-1:0]        step_cnt,
    input  logic                    load,
    input  logic [NUM_ROTORS*W-1:0] load_pos,
    output logic [NUM_ROTORS*W-1:0] pos,
    output logic                    busy,
    output logic                    done,
    output logic                    wrap,
    output logic                    load_err
);

    localparam logic [W:0] MOD_X = (W+1)'(MOD);

    state_t             state;
    mode_t              mode_q;
    logic               dir_q;
    logic [CNT_W-1:0]   remaining;

    logic [NUM_ROTORS-1:0] at_max;
    logic [NUM_ROTORS-1:0] at_zero;
    logic [NUM_ROTORS-1:0] at_notch;
    logic [NUM_ROTORS-1:0] step_en;
    logic [NUM_ROTORS-1:0] cell_step;
    logic                  chain_max;
    logic                  chain_zero;
    logic                  step_now;
    logic                  fwd;
    logic                  last_wrap;
    logic                  any_bad;

    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_cell
        rotor_cell #(
            .MOD   (MOD),
            .W     (W),
            .NOTCH (NOTCH_POS[g*W +: W])
        ) u_cell (
            .clk      (clk),
            .clear    (rst),
            .step     (cell_step[g]),
            .dir      (!fwd),
            .load     (load),
            .load_val (load_pos[g*W +: W]),
            .pos      (pos[g*W +: W]),
            .at_max   (at_max[g]),
            .at_zero  (at_zero[g]),
            .at_notch (at_notch[g])
        );
    end

    // All decisions use pre-step positions; the last rotor never double-steps.
    always_comb begin
        step_en    = '0;
        step_en[0] = 1'b1;
        chain_max  = 1'b1;
        chain_zero = 1'b1;
        for (int unsigned i = 1; i < NUM_ROTORS; i++) begin
            chain_max  = chain_max  && at_max[i-1];
            chain_zero = chain_zero && at_zero[i-1];
            if (mode_q == MODE_ENIGMA)
                step_en[i] = at_notch[i-1] || ((i + 1 < NUM_ROTORS) && at_notch[i]);
            else if (dir_q)
                step_en[i] = chain_zero;
            else
                step_en[i] = chain_max;
        end
    end

    always_comb begin
        fwd       = (mode_q == MODE_ENIGMA) || !dir_q;
        step_now  = (state == RUN) && !load;
        cell_step = step_now ? step_en : '0;
        last_wrap = step_now && step_en[NUM_ROTORS-1]
                    && (fwd ? at_max[NUM_ROTORS-1] : at_zero[NUM_ROTORS-1]);
        any_bad   = 1'b0;
        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
            if ({1'b0, load_pos[i*W +: W]} >= MOD_X)
                any_bad = 1'b1;
        end
    end

    // busy/done trail the state by one cycle; a load suppresses both immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_ODO;
            dir_q     <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wrap     <= last_wrap;
            load_err <= load && any_bad;
            busy     <= !load && (state != IDLE);
            done     <= !load && (state == DONE);
            if (load) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mode_q    <= mode_t'(mode);
                            dir_q     <= dir;
                            remaining <= step_cnt;
                            state     <= (step_cnt != '0) ? RUN : DONE;
                        end
                    end
                    RUN: begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1))
                            state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard bench for rotor_stepper: driver queues per-cycle expectations, monitor checks them.
module tb_rotor_stepper;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        dir;
    logic        start;
    logic [7:0]  step_cnt;
    logic        load;
    logic [14:0] load_pos;
    logic [14:0] pos;
    logic        busy;
    logic        done;
    logic        wrap;
    logic        load_err;

    typedef struct {
        string       nm;
        logic [14:0] pos;
        logic        busy;
        logic        done;
        logic        wrap;
        logic        lerr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    rotor_stepper #(
        .NUM_ROTORS (3),
        .MOD        (26),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .dir      (dir),
        .start    (start),
        .step_cnt (step_cnt),
        .load     (load),
        .load_pos (load_pos),
        .pos      (pos),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] P(input int a2, input int a1, input int a0);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [14:0] got, input logic [14:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.nm, "pos",      pos,             mon_e.pos);
            chk(mon_e.nm, "busy",     {14'd0, busy},     {14'd0, mon_e.busy});
            chk(mon_e.nm, "done",     {14'd0, done},     {14'd0, mon_e.done});
            chk(mon_e.nm, "wrap",     {14'd0, wrap},     {14'd0, mon_e.wrap});
            chk(mon_e.nm, "load_err", {14'd0, load_err}, {14'd0, mon_e.lerr});
        end
    end

    // Advance one edge, then queue what the DUT must show in the cycle that follows it.
    task automatic cyc(input string nm, input logic [14:0] p, input logic b,
                       input logic d, input logic w, input logic l);
        exp_t e;
        @(posedge clk);
        #1;
        e.nm = nm; e.pos = p; e.busy = b; e.done = d; e.wrap = w; e.lerr = l;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; dir = 1'b0; start = 1'b0;
        step_cnt = '0; load = 1'b0; load_pos = '0;

        cyc("rst0", P(0,0,0), 0, 0, 0, 0);
        cyc("rst1", P(0,0,0), 0, 0, 0, 0);
        rst = 1'b0;

        // Enigma double step: ADU -> ADV, AEW, BFX
        load = 1'b1; load_pos = P(0,3,20);
        cyc("en_load", P(0,3,20), 0, 0, 0, 0);
        load = 1'b0; mode = 1'b1; start = 1'b1; step_cnt = 8'd3;
        cyc("en_start", P(0,3,20), 0, 0, 0, 0);
        start = 1'b0;
        cyc("en_s1",   P(0,3,21), 1, 0, 0, 0);
        cyc("en_s2",   P(0,4,22), 1, 0, 0, 0);
        cyc("en_s3",   P(1,5,23), 1, 0, 0, 0);
        cyc("en_done", P(1,5,23), 1, 1, 0, 0);
        cyc("en_idle", P(1,5,23), 0, 0, 0, 0);

        // Odometer up rollover
        load = 1'b1; load_pos = P(25,25,24);
        cyc("up_load", P(25,25,24), 0, 0, 0, 0);
        load = 1'b0; mode = 1'b0; dir = 1'b0; start = 1'b1; step_cnt = 8'd2;
        cyc("up_start", P(25,25,24), 0, 0, 0, 0);
        start = 1'b0;
        cyc("up_s1",   P(25,25,25), 1, 0, 0, 0);
        cyc("up_s2",   P(0,0,0),    1, 0, 1, 0);
        cyc("up_done", P(0,0,0),    1, 1, 0, 0);
        cyc("up_idle", P(0,0,0),    0, 0, 0, 0);

        // Odometer down underflow
        load = 1'b1; load_pos = P(0,0,0);
        cyc("dn_load", P(0,0,0), 0, 0, 0, 0);
        load = 1'b0; dir = 1'b1; start = 1'b1; step_cnt = 8'd1;
        cyc("dn_start", P(0,0,0),    0, 0, 0, 0);
        start = 1'b0;
        cyc("dn_s1",   P(25,25,25), 1, 0, 1, 0);
        cyc("dn_done", P(25,25,25), 1, 1, 0, 0);
        cyc("dn_idle", P(25,25,25), 0, 0, 0, 0);

        // Load with a bad field aborts a 10-step burst
        dir = 1'b0; start = 1'b1; step_cnt = 8'd10;
        cyc("ab_start", P(25,25,25), 0, 0, 0, 0);
        start = 1'b0;
        cyc("ab_s1", P(0,0,0), 1, 0, 1, 0);
        cyc("ab_s2", P(0,0,1), 1, 0, 0, 0);
        cyc("ab_s3", P(0,0,2), 1, 0, 0, 0);
        load = 1'b1; load_pos = P(30,1,2);
        cyc("ab_load", P(0,1,2), 0, 0, 0, 1);
        load = 1'b0;
        for (int k = 0; k < 4; k++)
            cyc("ab_quiet", P(0,1,2), 0, 0, 0, 0);

        // Reset in the middle of a burst, then a normal burst
        start = 1'b1; step_cnt = 8'd5;
        cyc("rb_start", P(0,1,2), 0, 0, 0, 0);
        start = 1'b0;
        cyc("rb_s1", P(0,1,3), 1, 0, 0, 0);
        cyc("rb_s2", P(0,1,4), 1, 0, 0, 0);
        rst = 1'b1;
        cyc("rb_rst0", P(0,0,0), 0, 0, 0, 0);
        cyc("rb_rst1", P(0,0,0), 0, 0, 0, 0);
        rst = 1'b0;
        cyc("rb_quiet", P(0,0,0), 0, 0, 0, 0);
        start = 1'b1; step_cnt = 8'd1;
        cyc("rb_restart", P(0,0,0), 0, 0, 0, 0);
        start = 1'b0;
        cyc("rb_s1b",  P(0,0,1), 1, 0, 0, 0);
        cyc("rb_done", P(0,0,1), 1, 1, 0, 0);
        cyc("rb_idle", P(0,0,1), 0, 0, 0, 0);

        // Zero-length burst
        start = 1'b1; step_cnt = 8'd0;
        cyc("z_start", P(0,0,1), 0, 0, 0, 0);
        start = 1'b0;
        cyc("z_done", P(0,0,1), 1, 1, 0, 0);
        cyc("z_idle", P(0,0,1), 0, 0, 0, 0);

        // Start held while busy is ignored; burst length stays 3
        start = 1'b1; step_cnt = 8'd3;
        cyc("ib_start", P(0,0,1), 0, 0, 0, 0);
        step_cnt = 8'd7;
        cyc("ib_s1", P(0,0,2), 1, 0, 0, 0);
        cyc("ib_s2", P(0,0,3), 1, 0, 0, 0);
        start = 1'b0;
        cyc("ib_s3",   P(0,0,4), 1, 0, 0, 0);
        cyc("ib_done", P(0,0,4), 1, 1, 0, 0);
        cyc("ib_idle", P(0,0,4), 0, 0, 0, 0);
        cyc("ib_hold", P(0,0,4), 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rotor_stepper.md
Name: rotor_stepper

Overview:
- Parametrised successor of the free-running 8-bit counter. Holds NUM_ROTORS modulo-MOD position counters.
- Steps them as a chain in one of two modes: odometer (pure carry, up or down) or Enigma (notch-driven, with the double-step anomaly).
- A start/busy/done burst FSM applies a requested number of steps, one per clock.
- Sits between the top-level pin wrapper and the cipher datapath; it supplies rotor offsets.

Parameters:
- NUM_ROTORS, 3, number of chained rotors; index 0 is the fastest (rightmost) rotor.
- MOD, 26, modulus of each rotor; positions range 0..MOD-1.
- W, $clog2(MOD) (5), width of one position field.
- CNT_W, 8, width of the burst step count.
- NOTCH_POS, {5'd16,5'd4,5'd21}, packed NUM_ROTORS*W; field i is rotor i's notch. Default is rotors I/II/III: 0=V(21), 1=E(4), 2=Q(16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mode  in  1  0=odometer, 1=Enigma; sampled only on start
- dir  in  1  odometer direction, 0=up, 1=down; ignored in Enigma mode; sampled on start
- start  in  1  begin a burst; ignored while busy
- step_cnt  in  CNT_W  number of steps in the burst; sampled on start
- load  in  1  parallel load of all positions
- load_pos  in  NUM_ROTORS*W  load value; field i (bits i*W+:W) goes to rotor i
- pos  out  NUM_ROTORS*W  current positions, same packing
- busy  out  1  high while a burst is in progress (state != IDLE)
- done  out  1  one-cycle pulse at the end of a burst
- wrap  out  1  one-cycle pulse on any cycle where the slowest rotor wraps (MOD-1->0 or 0->MOD-1)
- load_err  out  1  one-cycle pulse when any load field is >= MOD

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - pos=0, state=IDLE, busy=0, done=0, wrap=0, load_err=0.
  - rst has priority over everything else.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches mode, dir and step_cnt into remaining. Goes to RUN if step_cnt!=0, else DONE.
  - RUN: one step per cycle, remaining decrements. When remaining==1 on a step, go to DONE.
  - DONE: done=1 for this cycle, then IDLE.
- Latency and signals:
  - A burst of N>=1 steps launched at edge t changes pos at edges t+1..t+N; done is high in cycle t+N+1.
  - busy is registered from state: high from the cycle after start until the cycle done is high, inclusive.
- Load:
  - Allowed in any state; wins over stepping in the same cycle.
  - In RUN or DONE, load aborts the burst: state goes to IDLE, no done pulse.
  - A field >= MOD loads 0 for that rotor; the other fields load normally; load_err pulses the next cycle.
- Step rule: every rotor's step decision is evaluated from pre-step positions of the same cycle.
- Odometer, up:
  - Rotor 0 always steps.
  - Rotor i steps iff all rotors j<i are at MOD-1.
  - A stepping rotor at MOD-1 goes to 0.
- Odometer, down:
  - Rotor 0 always steps.
  - Rotor i steps iff all rotors j<i are at 0.
  - A stepping rotor at 0 goes to MOD-1.
- Enigma (always forward):
  - Rotor 0 always steps.
  - Rotor i>=1 steps iff rotor i-1 is at its notch, OR (i<NUM_ROTORS-1 AND rotor i is at its notch). The second term is the double step.
  - The last rotor never double-steps.
  - Wrap is modulo MOD.
- wrap: registered pulse, asserted the cycle after the edge on which rotor NUM_ROTORS-1 wraps.
- Arithmetic: no rotor ever holds a value >= MOD, under any sequence of inputs.
- NUM_ROTORS=1: rotor 0 only; Enigma and odometer up modes behave identically.

Decomposition:
- Package rotor_pkg: state enum (IDLE/RUN/DONE), default MOD and NOTCH constants, and the mode encoding.
- Sub-module rotor_cell: one mod-MOD register with step/dir/load/clear inputs and at_max/at_zero/at_notch outputs.
- The top instantiates NUM_ROTORS rotor_cells in a generate loop. The top holds the step-enable chain logic and the FSM.

Test Plan:
- Reset: rst high for 2 cycles in the middle of a burst -> pos=0, busy=0, done=0 on the next cycle; a later start works normally.
- Enigma double step: load {0,3,20} (A,D,U), mode=1, start with step_cnt=3 -> pos reads ADV, AEW, BFX, i.e. {0,3,21}, {0,4,22}, {1,5,23}. done is high exactly 4 cycles after the start edge.
- Odometer up rollover: load {25,25,24}, mode=0, dir=0, step_cnt=2 -> {25,25,25}, then {0,0,0}; wrap pulses once.
- Odometer down: load {0,0,0}, dir=1, step_cnt=1 -> {25,25,25}; wrap pulses once.
- Load abort and error: during a 10-step burst, load {30,1,2} -> pos={0,1,2}, load_err pulses, busy drops the next cycle, done never asserts.
- Zero/ignored start: start with step_cnt=0 -> pos unchanged, done one cycle later. A start asserted while busy -> ignored; the step count is unchanged.
